// File: rtl/sim_uart_mmio_if.sv
// Data-memory bus between the CPU port (master) and the UART window (slave).
interface sim_uart_mmio_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output ce, we, addr, sel, wdata, input rdata, hit);
  modport slave  (input ce, we, addr, sel, wdata, output rdata, hit);
endinterface

// File: rtl/sim_uart_mmio.sv
// Memory-mapped simulation UART: stores become character strobes, and a
// periodic poller fills an RX FIFO that the CPU drains with loads.
module sim_uart_mmio #(
  parameter logic [31:0] BASE_ADDR     = 32'h1FE001E0,
  parameter int          RX_DEPTH      = 8,
  parameter int          POLL_INTERVAL = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sim_uart_mmio_if.slave        bus,
  output logic                  uart_out_valid,
  output logic [7:0]            uart_out_ch,
  output logic                  uart_in_valid,
  input  logic [7:0]            uart_in_ch
);
  localparam int PTR_W  = $clog2(RX_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PCNT_W = $clog2(POLL_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RX_DEPTH);
  localparam logic [PCNT_W-1:0] PLAST_C = PCNT_W'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAPTURE} poll_state_t;

  poll_state_t        state_q, state_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [7:0]         fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               rx_enable_q;

  logic        access, tx_wr, rx_rd, ctrl_wr, flush, pop, push, fifo_full, rx_valid;
  logic [1:0]  offset;
  logic [3:0]  status_cnt;
  logic [31:0] rdata_d;
  logic        unused_bits;

  assign offset     = bus.addr[3:2];
  assign access     = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign tx_wr      = access && bus.we && (offset == 2'd0) && bus.sel[0];
  assign rx_rd      = access && !bus.we && (offset == 2'd0);
  assign ctrl_wr    = access && bus.we && (offset == 2'd2) && bus.sel[0];
  assign flush      = ctrl_wr && bus.wdata[1];
  assign rx_valid   = (count_q != '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = rx_rd && rx_valid;
  // A flush in the capture cycle also throws away the arriving reply.
  assign push       = (state_q == CAPTURE) && (uart_in_ch != 8'hFF) && !flush;
  assign status_cnt = 4'(count_q);
  assign unused_bits = ^{bus.addr[1:0], bus.sel[3:1], bus.wdata[31:8]};

  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    uart_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_enable_q && !fifo_full) begin
          if (pcnt_q == PLAST_C) begin
            pcnt_d  = '0;
            state_d = REQ;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      REQ: begin
        uart_in_valid = 1'b1;
        state_d       = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rx_enable_q <= 1'b1;
    end else begin
      if (ctrl_wr) rx_enable_q <= bus.wdata[0];
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= uart_in_ch;
  end

  always_comb begin
    rdata_d = '0;
    if (access && !bus.we) begin
      case (offset)
        2'd0:    if (rx_valid) rdata_d = {24'b0, fifo_mem[rd_ptr_q]};
        2'd1:    rdata_d = {24'b0, status_cnt, 2'b0, 1'b1, rx_valid};
        2'd2:    rdata_d = {31'b0, rx_enable_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // Registered bus response and character strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rdata      <= '0;
      bus.hit        <= 1'b0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
    end else begin
      bus.rdata      <= rdata_d;
      bus.hit        <= access;
      uart_out_valid <= tx_wr;
      if (tx_wr) uart_out_ch <= bus.wdata[7:0];
    end
  end
endmodule

// File: tb/tb_sim_uart_mmio.sv
// Scoreboard bench for sim_uart_mmio: directed bus traffic and a scripted harness.
`timescale 1ns/1ps
module tb_sim_uart_mmio;
  localparam logic [31:0] BASE = 32'h1FE001E0;
  localparam int          PI   = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_out_valid, uart_in_valid;
  logic [7:0] uart_out_ch;
  logic [7:0] uart_in_ch;

  sim_uart_mmio_if bus();

  sim_uart_mmio #(.BASE_ADDR(BASE), .RX_DEPTH(8), .POLL_INTERVAL(PI)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
    .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t       rd_q[$];
  exp_t       tx_q[$];
  logic [7:0] reply_q[$];
  logic [7:0] dflt_reply = 8'hFF;
  int compared = 0, mismatched = 0, cyc = 0, poll_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Harness: answers each poll request on the following cycle
  always @(posedge clock) begin
    logic [7:0] nxt;
    if (reset_n && uart_in_valid) begin
      poll_cnt++;
      nxt = (reply_q.size() != 0) ? reply_q.pop_front() : dflt_reply;
      #1 uart_in_ch = nxt;
    end
  end

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (bus.hit) begin
        if (rd_q.size() == 0) check("unexpected_hit", {31'b0, bus.hit}, 32'h0);
        else begin
          e = rd_q.pop_front();
          check("rdata", bus.rdata, e.data);
          check("rdata_cycle", cyc, e.due);
        end
      end
      if (uart_out_valid) begin
        if (tx_q.size() == 0) check("unexpected_strobe", {31'b0, uart_out_valid}, 32'h0);
        else begin
          e = tx_q.pop_front();
          check("uart_out_ch", {24'b0, uart_out_ch}, e.data);
          check("strobe_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic bus_set(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
    bus.ce = 1'b1; bus.we = w; bus.addr = a; bus.sel = s; bus.wdata = d;
  endtask

  task automatic wr(input logic [1:0] off, input logic [3:0] s, input logic [31:0] d);
    bus_set(1'b1, BASE + {28'b0, off, 2'b00}, s, d);
    rd_q.push_back('{32'h0, cyc + 1});
    if (off == 2'd0 && s[0]) tx_q.push_back('{{24'b0, d[7:0]}, cyc + 1});
    @(posedge clock); #1;
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp_v);
    bus_set(1'b0, BASE + {28'b0, off, 2'b00}, 4'hF, 32'h0);
    rd_q.push_back('{exp_v, cyc + 1});
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    bus.ce = 1'b0; bus.we = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (reply_q.size() != 0 && n < 400) begin @(posedge clock); #1; n++; end
    check(name, reply_q.size(), 0);
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, e_pop;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.wdata = '0;
    uart_in_ch = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_hit", {31'b0, bus.hit}, 32'h0);
    check("reset_out_valid", {31'b0, uart_out_valid}, 32'h0);
    check("reset_out_ch", {24'b0, uart_out_ch}, 32'h0);
    check("reset_in_valid", {31'b0, uart_in_valid}, 32'h0);
    reset_n = 1'b1;
    idle(1);
    rd(2'd2, 32'h1);
    rd(2'd1, 32'h02);
    idle(1);

    // Single and back-to-back TX, masked lane, non-hit, reserved
    wr(2'd0, 4'b0001, 32'h41);
    idle(2);
    wr(2'd0, 4'b0001, 32'h48);
    wr(2'd0, 4'b0001, 32'h49);
    wr(2'd0, 4'b0010, 32'h4A);
    idle(2);
    bus_set(1'b1, BASE + 32'h10, 4'b0001, 32'h4B);
    @(posedge clock); #1;
    bus_set(1'b0, BASE - 32'h10, 4'hF, 32'h0);
    @(posedge clock); #1;
    check("nonhit_hit", {31'b0, bus.hit}, 32'h0);
    check("nonhit_rdata", bus.rdata, 32'h0);
    idle(1);
    wr(2'd3, 4'hF, 32'hDEAD);
    rd(2'd3, 32'h0);
    idle(1);

    // Three polls, one without a character
    reply_q = '{8'h61, 8'hFF, 8'h62};
    wait_drain("drain_3polls");
    rd(2'd1, 32'h23);
    rd(2'd0, 32'h61);
    rd(2'd0, 32'h62);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h02);
    idle(1);

    // Fill to capacity, polling stops, one pop re-arms it
    dflt_reply = 8'h55;
    idle(200);
    rd(2'd1, 32'h83);
    idle(1);
    p0 = poll_cnt;
    idle(40);
    check("no_poll_when_full", poll_cnt - p0, 0);
    e_pop = cyc + 1;
    rd(2'd0, 32'h55);
    idle(0);
    n = 0;
    while (!uart_in_valid && n < 100) begin @(negedge clock); n++; end
    check("poll_after_pop_cycle", cyc, e_pop + PI);
    @(posedge clock); #1;
    idle(2);
    rd(2'd1, 32'h83);
    idle(1);

    // Pop coinciding with a push at count 3, then flush
    dflt_reply = 8'hFF;
    wr(2'd2, 4'b0001, 32'h3);
    idle(1);
    reply_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    n = 0;
    while (!(reply_q.size() == 1 && uart_in_valid) && n < 400) begin @(negedge clock); n++; end
    check("poll4_seen", {31'b0, uart_in_valid}, 32'h1);
    @(posedge clock); #1;
    rd(2'd0, 32'h10);
    idle(1);
    rd(2'd1, 32'h33);
    idle(1);
    wr(2'd2, 4'b0001, 32'h3);
    idle(1);
    rd(2'd1, 32'h02);
    rd(2'd2, 32'h1);
    idle(1);

    // Reset during CAPTURE with five bytes buffered and a strobe pending
    reply_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    n = 0;
    while (!(reply_q.size() == 1 && uart_in_valid) && n < 800) begin @(negedge clock); n++; end
    check("poll6_seen", {31'b0, uart_in_valid}, 32'h1);
    bus_set(1'b1, BASE, 4'b0001, 32'h5A);
    @(posedge clock); #3;
    bus.ce = 1'b0; bus.we = 1'b0;
    check("pre_reset_out_valid", {31'b0, uart_out_valid}, 32'h1);
    check("pre_reset_hit", {31'b0, bus.hit}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_out_valid", {31'b0, uart_out_valid}, 32'h0);
    check("mid_reset_out_ch", {24'b0, uart_out_ch}, 32'h0);
    check("mid_reset_hit", {31'b0, bus.hit}, 32'h0);
    check("mid_reset_rdata", bus.rdata, 32'h0);
    check("mid_reset_in_valid", {31'b0, uart_in_valid}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    rd(2'd1, 32'h02);
    rd(2'd2, 32'h1);
    idle(3);

    check("rd_queue_drained", rd_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
